// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
//
// UART receiver. The serial line is synchronized, then sampled on a 16x (by
// default) oversampling tick. A falling edge is qualified at mid start bit,
// data bits are shifted in LSB first, optional parity and the stop bit are
// checked, and the received word is presented with a one-clock valid strobe.
// The state encoding is shared with the TX path.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   s_tick      oversample enable, one clk wide, OVERSAMPLE x baud
//   rx          asynchronous serial input, idle high
//   rx_data     last received data word (holds until the next stop sample)
//   rx_valid    one-clock strobe: rx_data / parity_err / frame_err updated
//   parity_err  parity mismatch on the last frame
//   frame_err   stop bit sampled low on the last frame
//   busy        high whenever the FSM is not idle
//   state       idle=000, start=001, data=010, parity=011, stop=100
// -----------------------------------------------------------------------------
module uart_rx_fsm #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy,
   output logic [2:0]           state
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_END  = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic              PAR_ODD_B = (PARITY_ODD != 0);
   localparam logic              PAR_EN_B  = (PARITY_EN != 0);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b000,
      ST_START  = 3'b001,
      ST_DATA   = 3'b010,
      ST_PARITY = 3'b011,
      ST_STOP   = 3'b100
   } state_t;

   // Registered state
   logic                 r_rx_meta;
   logic                 r_rx_s;
   state_t               r_state;
   logic [TICK_W-1:0]    r_tick_cnt;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bad;     // parity result held until stop
   logic                 r_armed;       // cleared by a low stop bit (break)
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_parity_err;
   logic                 r_frame_err;

   // Next-state values
   state_t               w_state_nxt;
   logic [TICK_W-1:0]    w_tick_cnt_nxt;
   logic [BIT_W-1:0]     w_bit_cnt_nxt;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 w_par_bad_nxt;
   logic                 w_armed_nxt;
   logic [DATA_BITS-1:0] w_rx_data_nxt;
   logic                 w_rx_valid_nxt;
   logic                 w_parity_err_nxt;
   logic                 w_frame_err_nxt;

   // ---------------------------------------------------------------------------
   // Two-flop synchronizer for the asynchronous line.
   // NOTE: both flops reset to 1 (idle level) so leaving reset never looks
   // like a falling edge / start bit.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   // ---------------------------------------------------------------------------
   // State register.
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_tick_cnt   <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_par_bad    <= 1'b0;
         r_armed      <= 1'b1;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_tick_cnt   <= w_tick_cnt_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_shift      <= w_shift_nxt;
         r_par_bad    <= w_par_bad_nxt;
         r_armed      <= w_armed_nxt;
         r_rx_data    <= w_rx_data_nxt;
         r_rx_valid   <= w_rx_valid_nxt;
         r_parity_err <= w_parity_err_nxt;
         r_frame_err  <= w_frame_err_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state / output logic. Everything advances only on s_tick, except the
   // valid strobe which defaults low and therefore drops on the next clk.
   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned and no latch is inferred.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt      = r_state;
      w_tick_cnt_nxt   = r_tick_cnt;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_shift_nxt      = r_shift;
      w_par_bad_nxt    = r_par_bad;
      w_armed_nxt      = r_armed;
      w_rx_data_nxt    = r_rx_data;
      w_rx_valid_nxt   = 1'b0;
      w_parity_err_nxt = r_parity_err;
      w_frame_err_nxt  = r_frame_err;

      if (s_tick) begin
         unique case (r_state)
            ST_IDLE: begin
               if (!r_rx_s && r_armed) begin
                  w_state_nxt    = ST_START;
                  w_tick_cnt_nxt = '0;
               end else if (r_rx_s) begin
                  // Line released after a break: allow start detection again.
                  w_armed_nxt = 1'b1;
               end
            end

            ST_START: begin
               if (r_tick_cnt == TICK_MID) begin
                  if (!r_rx_s) begin
                     w_state_nxt    = ST_DATA;
                     w_tick_cnt_nxt = '0;
                     w_bit_cnt_nxt  = '0;
                  end else begin
                     // Low pulse shorter than half a bit: treat as noise.
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
               end
            end

            ST_DATA: begin
               if (r_tick_cnt == TICK_END) begin
                  // LSB arrives first, so shift right and insert at the MSB.
                  w_shift_nxt    = {r_rx_s, r_shift[DATA_BITS-1:1]};
                  w_tick_cnt_nxt = '0;
                  if (r_bit_cnt == BIT_LAST) begin
                     w_state_nxt = PAR_EN_B ? ST_PARITY : ST_STOP;
                  end else begin
                     w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                  end
               end else begin
                  w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
               end
            end

            ST_PARITY: begin
               if (r_tick_cnt == TICK_END) begin
                  w_par_bad_nxt  = ((^r_shift) ^ r_rx_s) != PAR_ODD_B;
                  w_tick_cnt_nxt = '0;
                  w_state_nxt    = ST_STOP;
               end else begin
                  w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
               end
            end

            ST_STOP: begin
               if (r_tick_cnt == TICK_END) begin
                  w_rx_data_nxt    = r_shift;
                  w_parity_err_nxt = PAR_EN_B & r_par_bad;
                  w_frame_err_nxt  = ~r_rx_s;
                  w_rx_valid_nxt   = 1'b1;
                  w_tick_cnt_nxt   = '0;
                  w_state_nxt      = ST_IDLE;
                  // A low stop bit may be the start of a break; hold off start
                  // detection until the line has been seen high again.
                  if (!r_rx_s) begin
                     w_armed_nxt = 1'b0;
                  end
               end else begin
                  w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
               end
            end

            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign parity_err = r_parity_err;
   assign frame_err  = r_frame_err;
   assign busy       = (r_state != ST_IDLE);
   assign state      = r_state;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
//
// Bench for uart_rx_fsm with default parameters. Frames are driven one line
// level per bit period, aligned just after an s_tick edge. For each frame the
// bench predicts, from the frame layout alone, the tick on which the stop bit
// is sampled and the word/flags that must appear; a compare process checks
// the outputs against that expectation on every clock.
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm;

   localparam int DB         = 8;
   localparam int OS         = 16;
   localparam int PEN        = 1;
   localparam int PODD       = 0;
   localparam int FRAME_BITS = 1 + DB + PEN + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_tick;
   logic          rx;
   logic [DB-1:0] rx_data;
   logic          rx_valid;
   logic          parity_err;
   logic          frame_err;
   logic          busy;
   logic [2:0]    state;

   uart_rx_fsm #(
      .DATA_BITS (DB),
      .OVERSAMPLE(OS),
      .PARITY_EN (PEN),
      .PARITY_ODD(PODD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_tick    (s_tick),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .parity_err(parity_err),
      .frame_err (frame_err),
      .busy      (busy),
      .state     (state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Tick generator: one-clk pulses 3..5 clocks apart, so a line change made
   // just after one tick edge has passed the 2-FF synchronizer by the next.
   initial begin
      s_tick = 1'b0;
      forever begin
         repeat ($urandom_range(2, 4)) @(negedge clk);
         s_tick = 1'b1;
         @(negedge clk);
         s_tick = 1'b0;
      end
   end

   int n_ticks = 0;
   always @(posedge clk) if (s_tick) n_ticks <= n_ticks + 1;

   // ---------------------------------------------------------------------------
   // Reference model: expected strobes and the values the outputs must hold.
   // ---------------------------------------------------------------------------
   typedef struct {
      int            due;     // tick index of the stop-bit sample
      logic [DB-1:0] data;
      logic          perr;
      logic          ferr;
   } exp_t;

   exp_t          exp_q[$];
   int            valid_ticks[$];
   logic [DB-1:0] m_data = '0;
   logic          m_perr = 1'b0;
   logic          m_ferr = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0 && n_ticks > exp_q[0].due) begin
         check("rx_valid_missing", rx_valid, 1'b1);
         void'(exp_q.pop_front());
      end
      if (rx_valid) begin
         valid_ticks.push_back(n_ticks);
         if (exp_q.size() == 0) begin
            check("rx_valid_unexpected", rx_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("valid_tick", n_ticks, e.due);
            m_data = e.data;
            m_perr = e.perr;
            m_ferr = e.ferr;
         end
      end
      check("rx_data", rx_data, m_data);
      check("parity_err", parity_err, m_perr);
      check("frame_err", frame_err, m_ferr);
      check("busy", busy, state != 3'b000);
   end

   // State-change log for the sequence check of the first frame.
   bit         log_en = 1'b0;
   logic [2:0] st_log[$];
   always @(negedge clk) begin
      if (log_en && (st_log.size() == 0 || st_log[$] != state)) st_log.push_back(state);
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers. All return #1 after a tick edge.
   // ---------------------------------------------------------------------------
   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!s_tick) @(posedge clk);
      end
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      rx     = 1'b1;
      m_data = '0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      exp_q.delete();
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_parity_err", parity_err, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_busy", busy, 0);
      check("rst_state", state, 3'b000);
   endtask

   // Sends one frame. bad_par inverts the parity bit; stop_v is the stop level.
   // abort_bit >= 0 pulses rst five ticks into that bit position (0 = start).
   task automatic send_frame(input logic [DB-1:0] d, input bit bad_par,
                             input bit stop_v, input int abort_bit = -1);
      logic pbit;
      logic v;
      exp_t e;
      int   t0;
      pbit = (^d) ^ (PODD != 0) ^ bad_par;
      t0   = n_ticks;
      if (abort_bit < 0) begin
         // Start detected on tick t0+1, qualified OS/2 ticks later, then one
         // full bit period per data, parity and stop bit.
         e.due  = t0 + 1 + OS / 2 + OS * (DB + PEN + 1);
         e.data = d;
         e.perr = (PEN != 0) && bad_par;
         e.ferr = !stop_v;
         exp_q.push_back(e);
      end
      for (int b = 0; b < FRAME_BITS; b++) begin
         if (b == 0)                    v = 1'b0;
         else if (b <= DB)              v = d[b-1];
         else if (PEN != 0 && b == DB + 1) v = pbit;
         else                           v = stop_v;
         rx = v;
         if (b == abort_bit) begin
            wait_ticks(5);
            pulse_reset();
            return;
         end
         wait_ticks(OS);
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      wait_ticks(n);
   endtask

   // Watchdog: the run must never hang.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_checks);
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      logic [2:0] exp_seq[6];
      int         t_first;
      exp_seq = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};

      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      pulse_reset();
      idle(OS);

      // Good frame 0xA5, parity bit 0, with state sequence.
      st_log.delete();
      log_en = 1'b1;
      send_frame(8'hA5, 1'b0, 1'b1);
      idle(4);
      log_en = 1'b0;
      check("a5_data", rx_data, 8'hA5);
      check("a5_parity_err", parity_err, 1'b0);
      check("a5_frame_err", frame_err, 1'b0);
      check("a5_seq_len", st_log.size(), 6);
      for (int i = 0; i < 6 && i < st_log.size(); i++) check("a5_seq", st_log[i], exp_seq[i]);

      // 0x07 with a wrong parity bit (0 where even parity needs 1).
      send_frame(8'h07, 1'b1, 1'b1);
      idle(OS);
      check("p07_data", rx_data, 8'h07);
      check("p07_parity_err", parity_err, 1'b1);
      check("p07_frame_err", frame_err, 1'b0);

      // Glitch: five low ticks.
      rx = 1'b0;
      wait_ticks(1);
      check("glitch_start", state, 3'b001);
      wait_ticks(4);
      rx = 1'b1;
      wait_ticks(3);
      check("glitch_still_start", state, 3'b001);
      wait_ticks(1);
      check("glitch_back_idle", state, 3'b000);
      idle(OS);

      // Bad stop bit followed by a break, then a clean frame.
      send_frame(8'h3C, 1'b0, 1'b0);
      rx = 1'b0;
      wait_ticks(40);
      check("break_idle_state", state, 3'b000);
      check("break_frame_err", frame_err, 1'b1);
      check("break_data", rx_data, 8'h3C);
      idle(2 * OS);
      send_frame(8'h55, 1'b0, 1'b1);
      idle(OS);
      check("after_break_data", rx_data, 8'h55);
      check("after_break_frame_err", frame_err, 1'b0);

      // Reset during data bit 3, then a full frame.
      send_frame(8'hF0, 1'b0, 1'b1, 4);
      idle(2 * OS);
      send_frame(8'h81, 1'b0, 1'b1);
      idle(OS);
      check("post_rst_data", rx_data, 8'h81);
      check("post_rst_parity_err", parity_err, 1'b0);

      // Back-to-back frames with no idle time: strobes one frame length apart
      // (start + data + parity + stop = 11 bit periods with defaults).
      t_first = valid_ticks.size();
      send_frame(8'h12, 1'b0, 1'b1);
      send_frame(8'h34, 1'b0, 1'b1);
      idle(OS);
      check("b2b_count", valid_ticks.size() - t_first, 2);
      if (valid_ticks.size() - t_first == 2)
         check("b2b_spacing", valid_ticks[t_first+1] - valid_ticks[t_first], FRAME_BITS * OS);
      check("b2b_data", rx_data, 8'h34);

      // Random frames: random data, occasional bad parity / bad stop, random
      // idle gaps (at least one high tick after a low stop bit to re-arm).
      for (int n = 0; n < 24; n++) begin
         logic [DB-1:0] d;
         bit            bp;
         bit            sv;
         d  = DB'($urandom);
         bp = ($urandom_range(0, 3) == 0);
         sv = ($urandom_range(0, 4) != 0);
         send_frame(d, bp, sv);
         idle($urandom_range(sv ? 0 : 1, 20));
      end
      idle(2 * OS);

      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
